ifetch_line_server: RTL and testbench
=====================================

# ifetch_line_server

Local-store side of the instruction-fetch line interface: accepts a line request from the fetch stage, reads the 64-byte instruction line (16 x 32-bit words) from local store as four 128-bit quadword reads, assembles it, and presents it as one 512-bit line with a one-cycle valid pulse. It sits between the fetch stage's line buffer and the local-store arbiter, and keeps the last delivered line so that a repeated request (re-fetch after stall or branch into the same line) is served without a local-store access.

## Interface
- PC_W, default 16: width of the instruction-word address; line index = fetch_pc[PC_W-1:4].
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  line request; accepted only when fetch_busy=0 and flush=0.
- fetch_pc  in  PC_W  instruction-word address; low 4 bits ignored.
- flush  in  1  abort any fill, invalidate held line.
- fetch_busy  out  1  high in any state other than IDLE.
- line_valid  out  1  one-cycle pulse; line_data/line_tag valid.
- line_data  out  512  word i at bits [511-32i : 480-32i] (word 0 is the most significant).
- line_tag  out  PC_W-4  line index of line_data.
- ls_req  out  1  local-store quadword read request.
- ls_addr  out  PC_W-2  quadword address = {line index, qw[1:0]}.
- ls_gnt  in  1  read accepted in the cycle ls_req & ls_gnt.
- ls_rdata  in  128  data for the read accepted in the previous cycle; word 4q+j at bits [127-32j : 96-32j].

## Operation
- States: IDLE, FILL, DELIVER.
- IDLE: on accepted fetch_req, latch the line index into req_line. If hold_valid and req_line == line_tag (hit), go to DELIVER. Otherwise (miss), clear iss_cnt and ret_cnt (3 bits each, range 0..4) and go to FILL.
- FILL:
  - ls_req = (iss_cnt < 4), with ls_addr = {req_line, iss_cnt[1:0]}.
  - A read is accepted when ls_req & ls_gnt; on acceptance iss_cnt increments. Without a grant, ls_addr is held and nothing advances.
  - A one-bit pipeline flag records each accepted read. In the following cycle ls_rdata is written into hold quadword ret_cnt[1:0] and ret_cnt increments.
  - When ret_cnt reaches 4: hold_valid=1, line_tag=req_line, go to DELIVER.
- DELIVER: line_valid=1 for exactly one cycle, then go to IDLE. line_data is driven directly from the hold register.
- line_data/line_tag are stable from line_valid until the next miss enters FILL. During FILL they are undefined to the consumer.
- flush (any state): the next state is IDLE; ls_req=0 from the next cycle; hold_valid=0; no line_valid is issued.
  - Data returning for a read granted before the flush is discarded.
  - flush takes priority over a simultaneous fetch_req, which is dropped.
  - flush in DELIVER: line_valid is still high in that cycle (registered output), then IDLE.
- At most 4 reads are issued per fill, and at most one read is in flight per cycle.

## Timing
- Reset values: state IDLE, fetch_busy 0, line_valid 0, ls_req 0, ls_addr 0, line_data 0, line_tag 0, hold_valid 0, iss_cnt/ret_cnt 0.
- Request accepted in cycle 0 (hit): line_valid in cycle 1; fetch_busy high in cycle 1 only.
- Miss with ls_gnt held high: ls_req high in cycles 1-4 (qw 0..3), data captured in cycles 2-5, line_valid in cycle 6; fetch_busy high in cycles 1-6. The next request is accepted at the earliest in cycle 7.
- Each cycle of ls_gnt=0 while ls_req=1 adds one cycle of latency.
- ls_req drops in the cycle after the 4th grant. It is never asserted in IDLE or DELIVER.
- The ls_rdata capture in the final FILL cycle and the transition to DELIVER happen on the same edge.

## Test plan
- Reset, then fetch_pc=0x0020 miss with ls_gnt=1 and ls_rdata for qw k = {4 words 0xA0000000 + 4k+j} -> ls_addr 0x0008..0x000B in cycles 1-4; line_valid in cycle 6; word i of line_data = 0xA0000000+i; line_tag=0x002.
- Immediately re-request fetch_pc=0x002E -> hit: no ls_req, line_valid the next cycle, same line_data.
- Miss on fetch_pc=0x0040 with ls_gnt low on every other cycle -> ls_addr held while ungranted; line_valid in cycle 10; line_tag=0x004.
- flush in cycle 3 of a miss -> ls_req low from cycle 4; no line_valid; fetch_busy low in cycle 4; a later request to the same line misses (hold invalidated).
- fetch_req while fetch_busy=1, and fetch_req together with flush in IDLE -> both ignored: no ls_req, no line_valid.
- reset asserted mid-FILL (cycle 3) -> all outputs at reset values the next cycle; a following request to the prior line misses.

Source files
------------

// File: rtl/ifetch_line_server.sv
// ifetch_line_server: serves 64-byte instruction lines to the fetch stage.
// A miss is filled with four 128-bit local-store reads; the assembled line is
// held so a repeated request for the same line is answered without a read.
module ifetch_line_server #(
  parameter int PC_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic              flush,
  output logic              fetch_busy,
  output logic              line_valid,
  output logic [511:0]      line_data,
  output logic [PC_W-5:0]   line_tag,
  output logic              ls_req,
  output logic [PC_W-3:0]   ls_addr,
  input  logic              ls_gnt,
  input  logic [127:0]      ls_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DELIVER} state_t;

  state_t              state_q, state_d;
  logic [PC_W-5:0]     req_line_q, req_line_d;
  logic [2:0]          iss_cnt_q, iss_cnt_d;
  logic [2:0]          ret_cnt_q, ret_cnt_d;
  logic                pend_q, pend_d;
  // Quadword 0 lives in the top 128 bits, so quadword q is stored at index 3-q.
  logic [3:0][127:0]   hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [PC_W-5:0]     line_tag_q, line_tag_d;
  logic                ls_req_q, ls_req_d;
  logic [PC_W-3:0]     ls_addr_q, ls_addr_d;
  logic                fetch_busy_q, fetch_busy_d;
  logic                line_valid_q, line_valid_d;

  // Word offset within the line is irrelevant to a line-granular server.
  logic unused_pc_bits;
  assign unused_pc_bits = ^fetch_pc[3:0];

  // Next-state, fill bookkeeping and registered-output computation.
  always_comb begin
    state_d      = state_q;
    req_line_d   = req_line_q;
    iss_cnt_d    = iss_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    pend_d       = 1'b0;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    line_tag_d   = line_tag_q;

    case (state_q)
      S_IDLE: begin
        if (fetch_req) begin
          req_line_d = fetch_pc[PC_W-1:4];
          if (hold_valid_q && (fetch_pc[PC_W-1:4] == line_tag_q)) begin
            state_d = S_DELIVER;
          end else begin
            state_d      = S_FILL;
            iss_cnt_d    = 3'd0;
            ret_cnt_d    = 3'd0;
            // Hold contents are about to be overwritten piecewise.
            hold_valid_d = 1'b0;
          end
        end
      end
      S_FILL: begin
        if (ls_req_q && ls_gnt) begin
          iss_cnt_d = iss_cnt_q + 3'd1;
          pend_d    = 1'b1;
        end
        // Data arrives the cycle after its grant.
        if (pend_q) begin
          hold_d[~ret_cnt_q[1:0]] = ls_rdata;
          ret_cnt_d               = ret_cnt_q + 3'd1;
          if (ret_cnt_q == 3'd3) begin
            hold_valid_d = 1'b1;
            line_tag_d   = req_line_q;
            state_d      = S_DELIVER;
          end
        end
      end
      S_DELIVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a same-cycle request; data for
    // a read still in flight is dropped.
    if (flush) begin
      state_d      = S_IDLE;
      pend_d       = 1'b0;
      hold_d       = hold_q;
      hold_valid_d = 1'b0;
      line_tag_d   = line_tag_q;
    end

    ls_req_d     = (state_d == S_FILL) && (iss_cnt_d < 3'd4);
    ls_addr_d    = {req_line_d, iss_cnt_d[1:0]};
    fetch_busy_d = (state_d != S_IDLE);
    line_valid_d = (state_d == S_DELIVER);
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_line_q   <= '0;
      iss_cnt_q    <= 3'd0;
      ret_cnt_q    <= 3'd0;
      pend_q       <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      line_tag_q   <= '0;
      ls_req_q     <= 1'b0;
      ls_addr_q    <= '0;
      fetch_busy_q <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_line_q   <= req_line_d;
      iss_cnt_q    <= iss_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      pend_q       <= pend_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      line_tag_q   <= line_tag_d;
      ls_req_q     <= ls_req_d;
      ls_addr_q    <= ls_addr_d;
      fetch_busy_q <= fetch_busy_d;
      line_valid_q <= line_valid_d;
    end
  end

  assign fetch_busy = fetch_busy_q;
  assign line_valid = line_valid_q;
  assign line_data  = hold_q;
  assign line_tag   = line_tag_q;
  assign ls_req     = ls_req_q;
  assign ls_addr    = ls_addr_q;

endmodule

// File: tb/tb_ifetch_line_server.sv
// Directed bench for ifetch_line_server. Inputs change and outputs are
// sampled on the falling edge; "cycle c" counts rising edges after the
// cycle in which the request was presented (cycle 0).
module tb_ifetch_line_server;
  localparam int PC_W = 16;

  logic          clk = 1'b0;
  logic          reset, fetch_req, flush, ls_gnt;
  logic [15:0]   fetch_pc;
  logic [127:0]  ls_rdata;
  logic          fetch_busy, line_valid, ls_req;
  logic [511:0]  line_data;
  logic [11:0]   line_tag;
  logic [13:0]   ls_addr;

  int errors = 0;
  int checks = 0;

  ifetch_line_server #(.PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .flush(flush), .fetch_busy(fetch_busy), .line_valid(line_valid),
    .line_data(line_data), .line_tag(line_tag), .ls_req(ls_req),
    .ls_addr(ls_addr), .ls_gnt(ls_gnt), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  // Word w of line L: line 2 gives 0xA0000000+w, other lines are offset.
  function automatic logic [31:0] word_of(input logic [11:0] line, input int w);
    return 32'hA000_0000 + ((32'(line) - 32'd2) << 20) + 32'(w);
  endfunction

  function automatic logic [127:0] qw_of(input logic [13:0] a);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[127-32*j -: 32] = word_of(a[13:2], int'(a[1:0])*4 + j);
    return r;
  endfunction

  function automatic logic [511:0] line_of(input logic [11:0] line);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = word_of(line, i);
    return r;
  endfunction

  // Local-store model: one-cycle read latency after a grant, garbage otherwise.
  always @(posedge clk)
    ls_rdata <= (ls_req && ls_gnt) ? qw_of(ls_addr) : {4{32'hDEAD_BEEF}};

  task automatic tick();
    @(negedge clk);
  endtask

  // Plain stimulus: complete miss with grant always high.
  task automatic do_fill(input logic [15:0] pc);
    fetch_pc = pc; fetch_req = 1'b1; ls_gnt = 1'b1;
    tick(); fetch_req = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_req = 1'b0; flush = 1'b0; ls_gnt = 1'b0; fetch_pc = '0;
    tick(); tick();
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", fetch_busy); end
    checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL reset_lv got=%b exp=0", line_valid); end
    checks++; if (ls_req !== 1'b0) begin errors++; $display("FAIL reset_lsreq got=%b exp=0", ls_req); end
    checks++; if (ls_addr !== 14'h0) begin errors++; $display("FAIL reset_lsaddr got=%h exp=0", ls_addr); end
    checks++; if (line_data !== 512'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", line_data); end
    checks++; if (line_tag !== 12'h0) begin errors++; $display("FAIL reset_tag got=%h exp=0", line_tag); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_miss();
    fetch_pc = 16'h0020; fetch_req = 1'b1; ls_gnt = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick(); fetch_req = 1'b0;
      checks++; if (ls_req !== (c <= 4)) begin errors++; $display("FAIL miss_lsreq c=%0d got=%b", c, ls_req); end
      if (c <= 4) begin
        checks++; if (ls_addr !== 14'(8 + c - 1)) begin errors++; $display("FAIL miss_lsaddr c=%0d got=%h exp=%h", c, ls_addr, 14'(8 + c - 1)); end
      end
      checks++; if (line_valid !== (c == 6)) begin errors++; $display("FAIL miss_lv c=%0d got=%b", c, line_valid); end
      checks++; if (fetch_busy !== (c <= 6)) begin errors++; $display("FAIL miss_busy c=%0d got=%b", c, fetch_busy); end
      if (c == 6) begin
        checks++; if (line_data !== line_of(12'h002)) begin errors++; $display("FAIL miss_data got=%h exp=%h", line_data, line_of(12'h002)); end
        checks++; if (line_tag !== 12'h002) begin errors++; $display("FAIL miss_tag got=%h exp=002", line_tag); end
      end
    end
  endtask

  task automatic test_hit();
    fetch_pc = 16'h002E; fetch_req = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick(); fetch_req = 1'b0;
      checks++; if (ls_req !== 1'b0) begin errors++; $display("FAIL hit_lsreq c=%0d got=%b exp=0", c, ls_req); end
      checks++; if (line_valid !== (c == 1)) begin errors++; $display("FAIL hit_lv c=%0d got=%b", c, line_valid); end
      checks++; if (fetch_busy !== (c == 1)) begin errors++; $display("FAIL hit_busy c=%0d got=%b", c, fetch_busy); end
      if (c == 1) begin
        checks++; if (line_data !== line_of(12'h002)) begin errors++; $display("FAIL hit_data got=%h exp=%h", line_data, line_of(12'h002)); end
      end
    end
  endtask

  task automatic test_gnt_gaps();
    fetch_pc = 16'h0040; fetch_req = 1'b1; ls_gnt = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      tick(); fetch_req = 1'b0; ls_gnt = (c % 2 == 0);
      checks++; if (ls_req !== (c <= 8)) begin errors++; $display("FAIL gap_lsreq c=%0d got=%b", c, ls_req); end
      if (c <= 8) begin
        checks++; if (ls_addr !== 14'(16 + (c - 1) / 2)) begin errors++; $display("FAIL gap_lsaddr c=%0d got=%h exp=%h", c, ls_addr, 14'(16 + (c - 1) / 2)); end
      end
      checks++; if (line_valid !== (c == 10)) begin errors++; $display("FAIL gap_lv c=%0d got=%b", c, line_valid); end
      checks++; if (fetch_busy !== (c <= 10)) begin errors++; $display("FAIL gap_busy c=%0d got=%b", c, fetch_busy); end
      if (c == 10) begin
        checks++; if (line_data !== line_of(12'h004)) begin errors++; $display("FAIL gap_data got=%h exp=%h", line_data, line_of(12'h004)); end
        checks++; if (line_tag !== 12'h004) begin errors++; $display("FAIL gap_tag got=%h exp=004", line_tag); end
      end
    end
    ls_gnt = 1'b1;
  endtask

  task automatic test_flush();
    fetch_pc = 16'h0060; fetch_req = 1'b1; ls_gnt = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick(); fetch_req = 1'b0; flush = (c == 3);
      checks++; if (ls_req !== (c <= 3)) begin errors++; $display("FAIL flush_lsreq c=%0d got=%b", c, ls_req); end
      checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL flush_lv c=%0d got=%b exp=0", c, line_valid); end
      checks++; if (fetch_busy !== (c <= 3)) begin errors++; $display("FAIL flush_busy c=%0d got=%b", c, fetch_busy); end
    end
    // Line 4 was held before the flush; it must now miss.
    fetch_pc = 16'h0044; fetch_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick(); fetch_req = 1'b0;
      if (c == 1) begin
        checks++; if (ls_req !== 1'b1) begin errors++; $display("FAIL flush_remiss_lsreq got=%b exp=1", ls_req); end
        checks++; if (ls_addr !== 14'h010) begin errors++; $display("FAIL flush_remiss_addr got=%h exp=010", ls_addr); end
      end
      checks++; if (line_valid !== (c == 6)) begin errors++; $display("FAIL flush_remiss_lv c=%0d got=%b", c, line_valid); end
      if (c == 6) begin
        checks++; if (line_data !== line_of(12'h004)) begin errors++; $display("FAIL flush_remiss_data got=%h exp=%h", line_data, line_of(12'h004)); end
      end
    end
  endtask

  task automatic test_ignored();
    // Hit on line 4, then a request while busy.
    fetch_pc = 16'h0048; fetch_req = 1'b1;
    tick(); fetch_pc = 16'h0080;
    checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL ign_hit_lv got=%b exp=1", line_valid); end
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL ign_hit_busy got=%b exp=1", fetch_busy); end
    for (int c = 2; c <= 3; c++) begin
      tick(); fetch_req = 1'b0;
      checks++; if (ls_req !== 1'b0) begin errors++; $display("FAIL ign_busy_lsreq c=%0d got=%b exp=0", c, ls_req); end
      checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL ign_busy_busy c=%0d got=%b exp=0", c, fetch_busy); end
      checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL ign_busy_lv c=%0d got=%b exp=0", c, line_valid); end
    end
    // Request together with flush in IDLE.
    fetch_req = 1'b1; flush = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick(); fetch_req = 1'b0; flush = 1'b0;
      checks++; if (ls_req !== 1'b0) begin errors++; $display("FAIL ign_flush_lsreq c=%0d got=%b exp=0", c, ls_req); end
      checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL ign_flush_busy c=%0d got=%b exp=0", c, fetch_busy); end
      checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL ign_flush_lv c=%0d got=%b exp=0", c, line_valid); end
    end
  endtask

  task automatic test_reset_mid_fill();
    do_fill(16'h0020);
    fetch_pc = 16'h0040; fetch_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin tick(); fetch_req = 1'b0; end
    reset = 1'b1;
    tick(); reset = 1'b0;
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", fetch_busy); end
    checks++; if (ls_req !== 1'b0) begin errors++; $display("FAIL rst_mid_lsreq got=%b exp=0", ls_req); end
    checks++; if (ls_addr !== 14'h0) begin errors++; $display("FAIL rst_mid_lsaddr got=%h exp=0", ls_addr); end
    checks++; if (line_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_lv got=%b exp=0", line_valid); end
    checks++; if (line_data !== 512'h0) begin errors++; $display("FAIL rst_mid_data got=%h exp=0", line_data); end
    checks++; if (line_tag !== 12'h0) begin errors++; $display("FAIL rst_mid_tag got=%h exp=0", line_tag); end
    // Line 2 was held before reset; it must now miss.
    fetch_pc = 16'h0020; fetch_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick(); fetch_req = 1'b0;
      if (c == 1) begin
        checks++; if (ls_req !== 1'b1) begin errors++; $display("FAIL rst_remiss_lsreq got=%b exp=1", ls_req); end
        checks++; if (ls_addr !== 14'h008) begin errors++; $display("FAIL rst_remiss_addr got=%h exp=008", ls_addr); end
      end
      checks++; if (line_valid !== (c == 6)) begin errors++; $display("FAIL rst_remiss_lv c=%0d got=%b", c, line_valid); end
      if (c == 6) begin
        checks++; if (line_data !== line_of(12'h002)) begin errors++; $display("FAIL rst_remiss_data got=%h exp=%h", line_data, line_of(12'h002)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_gnt_gaps();
    test_flush();
    test_ignored();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
